// File: rtl/alu_seq_pkg.sv
// Shared opcodes, enums and the carry/shift-in selection helper for the
// sequential ALU execute stage.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADR = 5'b00001;
  localparam logic [4:0] OP_SBR = 5'b00101;
  localparam logic [4:0] OP_MLR = 5'b01001;
  localparam logic [4:0] OP_XSL = 5'b01010;
  localparam logic [4:0] OP_XSR = 5'b01011;

  typedef enum logic [1:0] {
    CM_ZERO = 2'b00,
    CM_ONE  = 2'b01,
    CM_FLAG = 2'b10,
    CM_MSB  = 2'b11
  } carry_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    IT_MUL = 2'b00,
    IT_SHL = 2'b01,
    IT_SHR = 2'b10
  } iter_op_e;

  // Add carry-in and shift-in bit; subtract uses the inverse of this.
  function automatic logic mode_bit(input carry_mode_e mode, input logic flag, input logic msb);
    logic b;
    case (mode)
      CM_ZERO: b = 1'b0;
      CM_ONE:  b = 1'b1;
      CM_FLAG: b = flag;
      CM_MSB:  b = msb;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Instruction/operand request and result response bundle between operand
// fetch, the execute stage and writeback.
interface alu_seq_exec_if #(
  parameter int DATA_W = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instr;
  logic [DATA_W-1:0] rn;
  logic [DATA_W-1:0] rm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              cout;
  logic              illegal;
  logic              carry;

  modport master (
    output in_valid, instr, rn, rm, out_ready,
    input  in_ready, out_valid, result, cout, illegal, carry
  );

  modport slave (
    input  in_valid, instr, rn, rm, out_ready,
    output in_ready, out_valid, result, cout, illegal, carry
  );

endinterface

// File: rtl/alu_seq_iter.sv
// Iterative datapath: shift-add multiplier and one-bit-per-cycle shifter
// sharing one accumulator pair and a down-counter.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  iter_op_e          op_i,
  input  logic [DATA_W-1:0] rn_i,
  input  logic [DATA_W-1:0] rm_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              sin_i,
  output logic              last_o,
  output logic [DATA_W-1:0] res_o,
  output logic              cout_o
);

  iter_op_e          op_q;
  logic              busy_q;
  logic              sin_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] mcand_q;

  logic [DATA_W:0]   sum_d;
  logic [DATA_W-1:0] hi_d;
  logic [DATA_W-1:0] lo_d;
  logic              cout_d;

  // One step of the selected operation; lo holds multiplier or shift source.
  always_comb begin
    sum_d  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(DATA_W + 1){1'b0}});
    hi_d   = hi_q;
    lo_d   = lo_q;
    cout_d = 1'b0;
    case (op_q)
      IT_MUL: begin
        hi_d   = sum_d[DATA_W:1];
        lo_d   = {sum_d[0], lo_q[DATA_W-1:1]};
        cout_d = |sum_d[DATA_W:1];
      end
      IT_SHL: begin
        lo_d   = {lo_q[DATA_W-2:0], sin_q};
        cout_d = lo_q[DATA_W-1];
      end
      IT_SHR: begin
        lo_d   = {sin_q, lo_q[DATA_W-1:1]};
        cout_d = lo_q[0];
      end
      default: begin
        cout_d = 1'b0;
      end
    endcase
  end

  // Outputs are the post-step values so the owner can capture on the last edge.
  assign last_o = busy_q && (cnt_q == CNT_W'(1));
  assign res_o  = lo_d;
  assign cout_o = cout_d;

  // Load on start, then step and count down until the final iteration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= IT_MUL;
      busy_q  <= 1'b0;
      sin_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      hi_q    <= {DATA_W{1'b0}};
      lo_q    <= {DATA_W{1'b0}};
      mcand_q <= {DATA_W{1'b0}};
    end else if (start_i) begin
      op_q    <= op_i;
      busy_q  <= 1'b1;
      sin_q   <= sin_i;
      cnt_q   <= cnt_i;
      hi_q    <= {DATA_W{1'b0}};
      lo_q    <= rm_i;
      mcand_q <= rn_i;
    end else if (busy_q) begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_q - CNT_W'(1);
      busy_q <= (cnt_q != CNT_W'(1));
    end else begin
      busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU execute stage: decode, single-cycle add/sub, control FSM,
// handshakes and the architectural CARRY flag.
module alu_seq_exec
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_seq_exec_if.slave bus
);

  state_e            state_q;
  logic [4:0]        opc_q;
  carry_mode_e       mode_q;
  logic [CNT_W-1:0]  sn_q;
  logic [DATA_W-1:0] rn_q;
  logic [DATA_W-1:0] rm_q;
  logic [DATA_W-1:0] result_q;
  logic              cout_q;
  logic              illegal_q;
  logic              out_valid_q;
  logic              carry_q;
  logic              upd_q;

  logic [4:0]        opc_in_d;
  carry_mode_e       mode_in_d;
  logic [CNT_W-1:0]  sn_in_d;
  logic [CNT_W-1:0]  it_cnt_d;
  logic              accept_d;
  logic              it_start_d;
  iter_op_e          it_op_d;
  logic              it_sin_d;
  logic [DATA_W-1:0] opb_d;
  logic              cin_d;
  logic [DATA_W:0]   sum_d;

  logic              it_last;
  logic [DATA_W-1:0] it_res;
  logic              it_cout;
  logic              unused_instr;

  assign unused_instr  = ^{bus.instr[10], bus.instr[3:0]};
  assign bus.in_ready  = (state_q == S_IDLE) && !rst_i;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.illegal   = illegal_q;
  assign bus.carry     = carry_q;

  // Decode of the incoming word and iterator launch on accept.
  always_comb begin
    opc_in_d  = bus.instr[15:11];
    mode_in_d = carry_mode_e'(bus.instr[9:8]);
    if (int'(bus.instr[7:4]) > DATA_W - 1) begin
      sn_in_d = CNT_W'(DATA_W - 1);
    end else begin
      sn_in_d = CNT_W'(bus.instr[7:4]);
    end
    accept_d   = bus.in_valid && bus.in_ready;
    it_sin_d   = mode_bit(mode_in_d, carry_q, bus.rm[DATA_W-1]);
    it_op_d    = IT_MUL;
    it_cnt_d   = sn_in_d;
    it_start_d = 1'b0;
    case (opc_in_d)
      OP_MLR: begin
        it_op_d    = IT_MUL;
        it_cnt_d   = CNT_W'(DATA_W);
        it_start_d = accept_d;
      end
      OP_XSL: begin
        it_op_d    = IT_SHL;
        it_start_d = accept_d && (sn_in_d != {CNT_W{1'b0}});
      end
      OP_XSR: begin
        it_op_d    = IT_SHR;
        it_start_d = accept_d && (sn_in_d != {CNT_W{1'b0}});
      end
      default: begin
        it_start_d = 1'b0;
      end
    endcase
  end

  // Single-cycle add/subtract on the captured operands.
  always_comb begin
    if (opc_q == OP_SBR) begin
      opb_d = ~rm_q;
      cin_d = ~mode_bit(mode_q, carry_q, rm_q[DATA_W-1]);
    end else begin
      opb_d = rm_q;
      cin_d = mode_bit(mode_q, carry_q, rm_q[DATA_W-1]);
    end
    sum_d = {1'b0, rn_q} + {1'b0, opb_d} + {{DATA_W{1'b0}}, cin_d};
  end

  alu_seq_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_iter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (it_start_d),
    .op_i    (it_op_d),
    .rn_i    (bus.rn),
    .rm_i    (bus.rm),
    .cnt_i   (it_cnt_d),
    .sin_i   (it_sin_d),
    .last_o  (it_last),
    .res_o   (it_res),
    .cout_o  (it_cout)
  );

  // Control FSM with registered result; CARRY commits only on result handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      opc_q       <= 5'b00000;
      mode_q      <= CM_ZERO;
      sn_q        <= {CNT_W{1'b0}};
      rn_q        <= {DATA_W{1'b0}};
      rm_q        <= {DATA_W{1'b0}};
      result_q    <= {DATA_W{1'b0}};
      cout_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            opc_q   <= opc_in_d;
            mode_q  <= mode_in_d;
            sn_q    <= sn_in_d;
            rn_q    <= bus.rn;
            rm_q    <= bus.rm;
            state_q <= S_EXEC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_EXEC: begin
          case (opc_q)
            OP_ADR, OP_SBR: begin
              result_q    <= sum_d[DATA_W-1:0];
              cout_q      <= sum_d[DATA_W];
              illegal_q   <= 1'b0;
              upd_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
            OP_MLR, OP_XSL, OP_XSR: begin
              // A zero-distance shift passes RM through and leaves CARRY alone.
              if ((opc_q != OP_MLR) && (sn_q == {CNT_W{1'b0}})) begin
                result_q    <= rm_q;
                cout_q      <= 1'b0;
                illegal_q   <= 1'b0;
                upd_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end else if (it_last) begin
                result_q    <= it_res;
                cout_q      <= it_cout;
                illegal_q   <= 1'b0;
                upd_q       <= 1'b1;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                state_q <= S_EXEC;
              end
            end
            default: begin
              result_q    <= {DATA_W{1'b0}};
              cout_q      <= 1'b0;
              illegal_q   <= 1'b1;
              upd_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          endcase
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
            if (upd_q) begin
              carry_q <= cout_q;
            end else begin
              carry_q <= carry_q;
            end
          end else begin
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Parametrised, multi-cycle successor to the processor's combinational ALU decode path. It accepts a 16-bit instruction word plus pre-selected operands Rn/Rm over a valid/ready handshake, decodes the arithmetic/shift/multiply group, and executes it. Add and subtract complete in a single cycle. Multiply and shifts are iterative, one bit per cycle. The block owns the CARRY flag register and sits between operand fetch and register-file writeback.

## Interface
- DATA_W, 16: operand/result width; legal values ≥ 8.
- CNT_W, $clog2(DATA_W+1): iteration counter width (derived; do not override).

- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  instruction and operands valid.
- IN_READY  out  1  block can accept; high only in IDLE.
- INSTR  in  16  instruction: [15:11] opcode, [9:8] carry/shift-in mode, [7:4] shift amount SN.
- RN  in  DATA_W  first operand.
- RM  in  DATA_W  second operand / shift source.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- RESULT  out  DATA_W  result.
- COUT  out  1  carry/borrow/shift-out of this result.
- ILLEGAL  out  1  opcode not in the supported set; qualified by OUT_VALID.
- CARRY  out  1  architectural carry flag.

## Operation
- Opcodes: ADR 00001, SBR 00101, MLR 01001, XSL 01010, XSR 01011. Any other opcode → ILLEGAL=1, RESULT=0, COUT=0, CARRY unchanged.
- Operands are captured on IN_VALID&IN_READY. RN/RM/INSTR are not sampled after capture.
- ADR: RESULT,COUT = RN + RM + cin. Carry-in by mode: 00→0, 01→1, 10→CARRY, 11→RM[DATA_W-1].
- SBR: RESULT,COUT = RN + ~RM + cin. Carry-in by mode: 00→1, 01→0, 10→~CARRY, 11→~RM[DATA_W-1]. COUT=1 means no borrow.
- MLR: RESULT = low DATA_W bits of RN*RM (unsigned), computed by shift-add over DATA_W iterations. COUT = 1 if any high product bit is nonzero.
- XSL/XSR: shift RM by SN (0..15, clamped to DATA_W-1), one position per cycle. Shift-in bit by mode: 00→0, 01→1, 10→CARRY, 11→RM[DATA_W-1] as captured (sign fill). COUT = last bit shifted out. SN=0 → RESULT=RM, COUT=0.
- The CARRY register loads COUT on OUT_VALID&OUT_READY for legal ops. Shifts with SN=0 leave CARRY unchanged.
- States:
  - IDLE → EXEC on accept.
  - EXEC → DONE: immediately for ADR/SBR/illegal; when the counter reaches 0 for MLR/shift.
  - DONE → IDLE on OUT_READY.

## Timing
- Reset values: IN_READY=0 during the RESET cycle and 1 after it; OUT_VALID=0, RESULT=0, COUT=0, ILLEGAL=0, CARRY=0; state=IDLE; counter=0.
- Latency, counted from the accept edge (cycle 0) to the first cycle OUT_VALID is high:
  - ADR/SBR/illegal: 2.
  - MLR: DATA_W+1.
  - Shift: max(SN,1)+1.
- At most one instruction is in flight. IN_READY is low from the accept edge until the result handshake completes; there is no back-to-back overlap.
- OUT_VALID stays high and RESULT/COUT/ILLEGAL stay stable while OUT_READY is low.
- IN_VALID asserted during the DONE→IDLE cycle is not accepted until IDLE is registered.
- RESET in any state aborts the operation in the same edge; the partial result is discarded and CARRY is cleared.
- CARRY changes only on the result-handshake edge. An op whose mode is 10 sees the CARRY value from before its own completion.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams;
  - carry-mode enum (CM_ZERO, CM_ONE, CM_FLAG, CM_MSB);
  - state enum (S_IDLE, S_EXEC, S_DONE).
- Sub-module alu_seq_iter contains the shared accumulator/shifter datapath and down-counter, driven by a start/op/done interface. alu_seq_exec keeps decode, single-cycle add/sub, FSM, handshake and the CARRY flag.

## Test plan
- ADR mode 00, RN=0xFFFF, RM=0x0001 → RESULT=0x0000, COUT=1, OUT_VALID 2 cycles after accept, CARRY=1 after handshake.
- SBR mode 00, RN=0x0005, RM=0x0007 → RESULT=0xFFFE, COUT=0. Then ADR mode 10 with RN=1, RM=1 → RESULT=0x0002.
- MLR, RN=0x0123, RM=0x0010 → RESULT=0x1230, COUT=0, OUT_VALID at cycle 17, IN_READY low throughout. RN=0x8000, RM=0x0002 → RESULT=0x0000, COUT=1.
- XSR mode 01, SN=4, RM=0x0F00 → RESULT=0xF0F0, COUT=0, latency 5. XSL mode 00, SN=0, RM=0xABCD → RESULT=0xABCD, CARRY unchanged.
- Hold OUT_READY low 3 cycles after ADR completes → RESULT stable, IN_VALID ignored. Illegal opcode 11111 → ILLEGAL=1, RESULT=0.
- Assert RESET at cycle 5 of MLR → next cycle IN_READY=1, OUT_VALID=0, CARRY=0. A following ADR 2+3 returns 0x0005.
